// File: rtl/formula_sqrt_sum_pipe_fsm.sv
// Sums isqrt(x[i]) over an N_ARGS argument vector using an external in-order isqrt pipe.
// Optional FORMULA_SQRT_SUM_RESP_CHECK_EN adds a sticky err output for unexpected responses.
`timescale 1ns/1ps
module formula_sqrt_sum_pipe_fsm #(
   parameter int N_ARGS = 3,
   parameter int W      = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                arg_vld,
   output logic                arg_rdy,
   input  logic [N_ARGS*W-1:0] args,
   output logic                res_vld,
   output logic [W-1:0]        res,
   output logic                isqrt_x_vld,
   output logic [W-1:0]        isqrt_x,
   input  logic                isqrt_y_vld,
   input  logic [W/2-1:0]      isqrt_y
`ifdef FORMULA_SQRT_SUM_RESP_CHECK_EN
   ,
   output logic                err
`endif
);

   localparam int IW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_ARGS - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   // Handshake: a vector moves in a cycle where arg_vld && arg_rdy; arg_vld is
   // level-held by the producer while arg_rdy is low and nothing is captured then.

   logic [0:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] idx_inc;
   logic [W-1:0]  buf_q [N_ARGS];
   logic [W-1:0]  buf_d [N_ARGS];
   logic          x_vld_q, x_vld_d;
   logic [W-1:0]  x_q, x_d;
   logic          last_issue;
   logic          accept;

   logic [IW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  res_q, res_d;
   logic          res_vld_q, res_vld_d;
   logic [W-1:0]  y_ext;

   // idx_q names the element currently presented on isqrt_x while in ISSUE.
   always_comb begin
      last_issue = (state_q == S_ISSUE) && (idx_q == LAST);
      arg_rdy    = (state_q == S_IDLE) || last_issue;
      accept     = arg_vld && arg_rdy;
      idx_inc    = last_issue ? '0 : idx_q + 1'b1;
      state_d    = state_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      x_vld_d    = 1'b0;
      x_d        = x_q;
      if (accept) begin
         state_d = S_ISSUE;
         idx_d   = '0;
         for (int i = 0; i < N_ARGS; i++) begin
            buf_d[i] = args[i*W +: W];
         end
         x_vld_d = 1'b1;
         x_d     = args[W-1:0];
      end else if ((state_q == S_ISSUE) && !last_issue) begin
         idx_d   = idx_inc;
         x_vld_d = 1'b1;
         x_d     = buf_q[idx_inc];
      end else if (state_q == S_ISSUE) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         x_vld_q <= 1'b0;
         x_q     <= '0;
         for (int i = 0; i < N_ARGS; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         x_vld_q <= x_vld_d;
         x_q     <= x_d;
         buf_q   <= buf_d;
      end
   end

   // Responses arrive in order, so a plain modulo-N_ARGS count frames each vector.
   always_comb begin
      y_ext     = {{(W - W/2){1'b0}}, isqrt_y};
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      res_d     = res_q;
      res_vld_d = 1'b0;
      if (isqrt_y_vld) begin
         if (cnt_q == LAST) begin
            res_d     = acc_q + y_ext;
            res_vld_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
         end else begin
            acc_d = acc_q + y_ext;
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         res_q     <= '0;
         res_vld_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         res_q     <= res_d;
         res_vld_q <= res_vld_d;
      end
   end

   assign isqrt_x_vld = x_vld_q;
   assign isqrt_x     = x_q;
   assign res_vld     = res_vld_q;
   assign res         = res_q;

`ifdef FORMULA_SQRT_SUM_RESP_CHECK_EN
   logic [7:0] outst_q, outst_d;
   logic       err_q, err_d;

   // A response with nothing outstanding is flagged even if a request issues the same cycle.
   always_comb begin
      outst_d = outst_q;
      err_d   = err_q;
      if (isqrt_y_vld && (outst_q == 8'd0)) begin
         err_d = 1'b1;
      end
      case ({x_vld_q, isqrt_y_vld})
         2'b10: begin
            if (outst_q == 8'hFF) begin
               err_d = 1'b1;
            end else begin
               outst_d = outst_q + 8'd1;
            end
         end
         2'b01: begin
            if (outst_q != 8'd0) begin
               outst_d = outst_q - 8'd1;
            end
         end
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_formula_sqrt_sum_pipe_fsm.sv
// Bench for formula_sqrt_sum_pipe_fsm (N_ARGS=3, W=32) with a latency-4 isqrt pipe model.
`timescale 1ns/1ps
module tb_formula_sqrt_sum_pipe_fsm;

   localparam int N = 3;
   localparam int W = 32;

   logic           clk;
   logic           rst_n;
   logic           arg_vld;
   logic           arg_rdy;
   logic [N*W-1:0] args;
   logic           res_vld;
   logic [W-1:0]   res;
   logic           isqrt_x_vld;
   logic [W-1:0]   isqrt_x;
   logic           isqrt_y_vld;
   logic [W/2-1:0] isqrt_y;
`ifdef FORMULA_SQRT_SUM_RESP_CHECK_EN
   logic           err;
`endif

   formula_sqrt_sum_pipe_fsm #(.N_ARGS(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .arg_vld(arg_vld), .arg_rdy(arg_rdy), .args(args),
      .res_vld(res_vld), .res(res),
      .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
      .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y)
`ifdef FORMULA_SQRT_SUM_RESP_CHECK_EN
      , .err(err)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] req_q[$];
   int          resp_cnt = 0;
   logic        pulse_due = 1'b0;
   int          run = 0;
   int          max_run = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic logic [15:0] isqrt_f(input logic [31:0] x);
      logic [15:0] r;
      logic [15:0] t;
      logic [31:0] sq;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t  = r | (16'd1 << b);
         sq = {16'd0, t} * {16'd0, t};
         if (sq <= x) r = t;
      end
      return r;
   endfunction

   // ---------------- isqrt pipe model (latency 4, in order) ----------------
   logic         pv [4];
   logic [W-1:0] px [4];
   logic         inj_vld;
   logic [15:0]  inj_y;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            pv[i] <= 1'b0;
            px[i] <= '0;
         end
      end else begin
         pv[0] <= isqrt_x_vld;
         px[0] <= isqrt_x;
         for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            px[i] <= px[i-1];
         end
      end
   end

   assign isqrt_y_vld = pv[3] | inj_vld;
   assign isqrt_y     = pv[3] ? isqrt_f(px[3]) : inj_y;

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         resp_cnt  = 0;
         pulse_due = 1'b0;
         run       = 0;
      end else begin
         if (res_vld || pulse_due) check("res_vld_timing", res_vld, pulse_due);
         if (res_vld) begin
            if (exp_q.size() == 0) fail_now("res_unexpected");
            else check("res_value", res, exp_q.pop_front());
         end
         pulse_due = isqrt_y_vld && (resp_cnt == N-1);
         if (isqrt_y_vld) resp_cnt = (resp_cnt == N-1) ? 0 : resp_cnt + 1;
         if (isqrt_x_vld) begin
            if (req_q.size() == 0) fail_now("req_unexpected");
            else check("req_operand", isqrt_x, req_q.pop_front());
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge; returns at the negedge after the accepting edge with arg_vld still high.
   task automatic send_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                           input logic [W-1:0] e, output int waits);
      args    = {c, b, a};
      arg_vld = 1'b1;
      waits   = 0;
      while (!arg_rdy && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (!arg_rdy) begin
         fail_now("accept_timeout");
      end else begin
         exp_q.push_back(e);
         req_q.push_back(a);
         req_q.push_back(b);
         req_q.push_back(c);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail_now("drain_timeout");
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [W-1:0] x0;
      logic [W-1:0] x1;
      logic [W-1:0] x2;
      logic [W-1:0] exp;
   } vec_t;

   vec_t tbl [7];

   // ---------------- test sequence ----------------
   initial begin
      int w;
      int n;
      logic [W-1:0] ra, rb, rc;

      tbl[0] = '{32'd9,          32'd16,         32'd25,         32'd12};
      tbl[1] = '{32'd1,          32'd4,          32'd100,        32'd13};
      tbl[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd196605};
      tbl[3] = '{32'd0,          32'd0,          32'd0,          32'd0};
      tbl[4] = '{32'd2,          32'd3,          32'd8,          32'd4};
      tbl[5] = '{32'd15,         32'd17,         32'd24,         32'd11};
      tbl[6] = '{32'd65536,      32'd1,          32'd0,          32'd257};

      rst_n   = 1'b0;
      arg_vld = 1'b0;
      args    = '0;
      inj_vld = 1'b0;
      inj_y   = '0;
      repeat (3) @(negedge clk);
      check("rst_arg_rdy", arg_rdy, 1);
      check("rst_res_vld", res_vld, 0);
      check("rst_res", res, 0);
      check("rst_x_vld", isqrt_x_vld, 0);
      check("rst_x", isqrt_x, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // single vector
      send_vec(32'd9, 32'd16, 32'd25, 32'd12, w);
      arg_vld = 1'b0;
      check("single_accept_wait", w, 0);
      drain();

      // back-to-back pair: six consecutive requests
      max_run = 0;
      send_vec(32'd9, 32'd16, 32'd25, 32'd12, w);
      send_vec(32'd1, 32'd4, 32'd100, 32'd13, w);
      arg_vld = 1'b0;
      check("b2b_hold_wait", w, 2);
      drain();
      check("b2b_vld_run", max_run, 6);

      // table vectors streamed back-to-back
      max_run = 0;
      for (int i = 0; i < 7; i++) begin
         send_vec(tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].exp, w);
      end
      arg_vld = 1'b0;
      drain();
      check("table_vld_run", max_run, 21);

      // held arg_vld while not ready: issued exactly once after arg_rdy rises
      send_vec(32'd49, 32'd64, 32'd81, 32'd24, w);
      send_vec(32'd121, 32'd144, 32'd169, 32'd36, w);
      arg_vld = 1'b0;
      check("hold_wait", w, 2);
      drain();
      check("hold_no_extra", req_q.size(), 0);

      // random vectors with random idle gaps
      for (int i = 0; i < 20; i++) begin
         ra = $urandom();
         rb = $urandom_range(0, 1000);
         rc = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom();
         send_vec(ra, rb, rc,
                  {16'd0, isqrt_f(ra)} + {16'd0, isqrt_f(rb)} + {16'd0, isqrt_f(rc)}, w);
         if ($urandom_range(0, 2) == 0) begin
            arg_vld = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
      end
      arg_vld = 1'b0;
      drain();

      // reset after two of three responses
      send_vec(32'd25, 32'd36, 32'd49, 32'd18, w);
      arg_vld = 1'b0;
      n = 0;
      while (resp_cnt != 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (resp_cnt != 2) fail_now("two_resp_timeout");
      rst_n = 1'b0;
      exp_q.delete();
      req_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("res_vld_in_reset", res_vld, 0);
      end
      check("rst_mid_x_vld", isqrt_x_vld, 0);
      rst_n = 1'b1;
      @(negedge clk);
      send_vec(32'd4, 32'd4, 32'd4, 32'd6, w);
      arg_vld = 1'b0;
      drain();

`ifdef FORMULA_SQRT_SUM_RESP_CHECK_EN
      check("err_before_inject", err, 0);
      inj_y   = 16'd7;
      inj_vld = 1'b1;
      @(negedge clk);
      inj_vld = 1'b0;
      check("err_after_inject", err, 1);
      repeat (5) @(negedge clk);
      check("err_sticky", err, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("err_cleared_by_reset", err, 0);
      rst_n = 1'b1;
      @(negedge clk);
`endif

      check("exp_q_empty", exp_q.size(), 0);
      check("req_q_empty", req_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "global timeout");
   end

endmodule
